snn_spi_config_loader: RTL and testbench

//  SPI slave (mode 0, MSB first) that loads the spiking network's weight/delay configuration memory.

---
 rtl/snn_spi_config_loader.sv | 186 ++++++++++++++++++
 tb/tb_snn_spi_config_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_spi_config_loader.sv
// SPI mode-0 slave (MSB first) that owns the spiking network's configuration
// memory. SCLK/SS/MOSI are oversampled in the system_clock domain. Command byte:
// bit7 = 1 for write, 0 for read; low ADDR_W bits = start address. The address
// auto-increments after every data byte. Reads return the memory over MISO.
module snn_spi_config_loader #(
  parameter int MEM_DEPTH = 72,
  parameter int ADDR_W    = 7
) (
  input  logic                   system_clock,
  input  logic                   reset,
  input  logic                   SCLK,
  input  logic                   MOSI,
  input  logic                   SS,
  output logic                   MISO,
  output logic [MEM_DEPTH*8-1:0] config_bus,
  output logic                   cfg_wr_strobe,
  output logic [ADDR_W-1:0]      cfg_wr_addr,
  output logic                   busy
);

  localparam logic [ADDR_W:0] MEM_DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  // [0]/[1] form the two-flop synchroniser; [2] is the edge-detect history
  logic [2:0]        sclk_pipe_q, sclk_pipe_d;
  logic [2:0]        ss_pipe_q, ss_pipe_d;
  logic [1:0]        mosi_pipe_q, mosi_pipe_d;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              miso_q, miso_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        mem_q [MEM_DEPTH];

  logic              sclk_rise, sclk_fall, ss_sync, ss_fall, mosi_sync;
  logic [7:0]        rx_byte;
  logic              byte_done;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  assign sclk_pipe_d = {sclk_pipe_q[1:0], SCLK};
  assign ss_pipe_d   = {ss_pipe_q[1:0], SS};
  assign mosi_pipe_d = {mosi_pipe_q[0], MOSI};

  assign sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
  assign sclk_fall = ~sclk_pipe_q[1] & sclk_pipe_q[2];
  assign ss_sync   = ss_pipe_q[1];
  assign ss_fall   = ~ss_pipe_q[1] & ss_pipe_q[2];
  assign mosi_sync = mosi_pipe_q[1];

  assign rx_byte   = {rx_shift_q[6:0], mosi_sync};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign addr_inc  = addr_q + ADDR_W'(1);

  // Readback source: the command's address when entering RDATA, else the next address
  assign rd_addr = (state_q == CMD) ? rx_byte[ADDR_W-1:0] : addr_inc;
  assign rd_data = ({1'b0, rd_addr} < MEM_DEPTH_C) ? mem_q[rd_addr] : 8'h00;

  // Next-state, shift, address and strobe logic for the SPI frame
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    addr_d     = addr_q;
    miso_d     = miso_q;
    strobe_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    mem_wdata  = rx_byte;

    if (ss_sync) begin
      // Deselect wins over any coincident SCLK edge; partial byte is discarded
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
      end
    end else begin
      if (sclk_rise) begin
        rx_shift_d = rx_byte;
        bit_cnt_d  = bit_cnt_q + 3'd1;
      end
      case (state_q)
        CMD: begin
          if (byte_done) begin
            addr_d = rx_byte[ADDR_W-1:0];
            if (rx_byte[7]) begin
              state_d = WDATA;
            end else begin
              state_d    = RDATA;
              tx_shift_d = rd_data;
            end
          end
        end
        WDATA: begin
          if (byte_done) begin
            if ({1'b0, addr_q} < MEM_DEPTH_C) begin
              mem_we    = 1'b1;
              strobe_d  = 1'b1;
              wr_addr_d = addr_q;
            end
            addr_d = addr_inc;
          end
        end
        RDATA: begin
          if (sclk_fall) begin
            miso_d     = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
          if (byte_done) begin
            addr_d     = addr_inc;
            tx_shift_d = rd_data;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and datapath registers
  always_ff @(posedge system_clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sclk_pipe_q <= 3'b000;
      ss_pipe_q   <= 3'b111;
      mosi_pipe_q <= 2'b00;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      strobe_q    <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      sclk_pipe_q <= sclk_pipe_d;
      ss_pipe_q   <= ss_pipe_d;
      mosi_pipe_q <= mosi_pipe_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      strobe_q    <= strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  // Configuration memory, written one byte per committed in-range data byte
  always_ff @(posedge system_clock or posedge reset) begin
    // NOTE: this memory is reset because it drives config_bus directly; the core must never see X weights.
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Flatten the memory onto the configuration bus
  always_comb begin
    config_bus = '0;
    for (int k = 0; k < MEM_DEPTH; k++) config_bus[8*k +: 8] = mem_q[k];
  end

  assign MISO          = miso_q;
  assign cfg_wr_strobe = strobe_q;
  assign cfg_wr_addr   = wr_addr_q;
  assign busy          = ~ss_sync;

endmodule

// File: tb/tb_snn_spi_config_loader.sv
// Self-checking bench for snn_spi_config_loader: hand-written vector table,
// randomized frames against a byte-array reference model, and corner sequences
// (abort mid-byte, read abort, reset mid-frame).
module tb_snn_spi_config_loader;

  localparam int MEM_DEPTH = 72;
  localparam int ADDR_W    = 7;
  localparam int HALF      = 6;  // system_clock cycles per SCLK half period

  logic                   system_clock = 1'b0;
  logic                   reset;
  logic                   SCLK, MOSI, SS;
  logic                   MISO;
  logic [MEM_DEPTH*8-1:0] config_bus;
  logic                   cfg_wr_strobe;
  logic [ADDR_W-1:0]      cfg_wr_addr;
  logic                   busy;

  snn_spi_config_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .SS           (SS),
    .MISO         (MISO),
    .config_bus   (config_bus),
    .cfg_wr_strobe(cfg_wr_strobe),
    .cfg_wr_addr  (cfg_wr_addr),
    .busy         (busy)
  );

  always #5 system_clock = ~system_clock;

  int tests  = 0;
  int failed = 0;

  // Reference model: plain byte array plus the list of writes it expects
  logic [7:0] mdl_mem [MEM_DEPTH];
  int         exp_addr[$];
  logic [7:0] exp_data[$];
  int         got_addr[$];
  logic [7:0] got_data[$];

  // Strobe monitor: record address and the byte visible on config_bus in the strobe cycle
  always @(negedge system_clock) begin
    if (!reset && cfg_wr_strobe) begin
      got_addr.push_back(int'(cfg_wr_addr));
      got_data.push_back(config_bus[8*cfg_wr_addr +: 8]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [MEM_DEPTH*8-1:0] model_bus();
    logic [MEM_DEPTH*8-1:0] b;
    for (int k = 0; k < MEM_DEPTH; k++) b[8*k +: 8] = mdl_mem[k];
    return b;
  endfunction

  task automatic check_bus(input string name);
    logic [MEM_DEPTH*8-1:0] exp;
    exp = model_bus();
    tests++;
    if (config_bus !== exp) begin
      failed++;
      $display("FAIL %s: config_bus got %h expected %h", name, config_bus, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < MEM_DEPTH; k++) mdl_mem[k] = 8'h00;
  endtask

  // Frame semantics: address walks mod 2**ADDR_W; out-of-range writes dropped, reads give 0
  task automatic model_frame(input logic [7:0] cmd, input int n, input logic [31:0] d,
                             output logic [31:0] rd);
    int a;
    logic [7:0] b;
    a  = int'(cmd[ADDR_W-1:0]);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      b = d[31-8*i -: 8];
      if (cmd[7]) begin
        if (a < MEM_DEPTH) begin
          mdl_mem[a] = b;
          exp_addr.push_back(a);
          exp_data.push_back(b);
        end
      end else begin
        rd[31-8*i -: 8] = (a < MEM_DEPTH) ? mdl_mem[a] : 8'h00;
      end
      a = (a + 1) % (1 << ADDR_W);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge system_clock);
  endtask

  // Mode 0 master: drive MOSI while SCLK low, sample MISO just before the rise
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[7-i];
      tick(HALF);
      rx[7-i] = MISO;
      SCLK = 1'b1;
      tick(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input int n, input logic [31:0] d,
                           output logic [31:0] rd);
    logic [7:0] b;
    rd = '0;
    SS = 1'b0;
    tick(HALF);
    spi_bits(cmd, 8, b);
    for (int i = 0; i < n; i++) begin
      spi_bits(d[31-8*i -: 8], 8, b);
      rd[31-8*i -: 8] = b;
    end
    tick(HALF);
    SS   = 1'b1;
    MOSI = 1'b0;
    tick(HALF);
  endtask

  task automatic clear_queues();
    exp_addr.delete();
    exp_data.delete();
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic check_strobes(input string tag);
    check($sformatf("%s strobe count", tag), got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s strobe%0d addr", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s strobe%0d data", tag, i), {24'h0, got_data[i]}, {24'h0, exp_data[i]});
    end
  endtask

  // Run one frame through both DUT and model; return both readbacks
  task automatic run_frame(input logic [7:0] cmd, input int n, input logic [31:0] d,
                           output logic [31:0] dut_rd, output logic [31:0] mdl_rd);
    clear_queues();
    model_frame(cmd, n, d, mdl_rd);
    spi_frame(cmd, n, d, dut_rd);
  endtask

  typedef struct packed {
    logic [7:0]  cmd;
    logic [2:0]  n;
    logic [31:0] d;        // data bytes, first byte in [31:24]
    logic [2:0]  strobes;  // expected strobe count
    logic [31:0] rd;       // expected readback, first byte in [31:24]
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] dut_rd, mdl_rd;
    logic [7:0]  b, cmd, exp_byte;
    int          n, sel;
    logic [31:0] d;

    vecs[0] = '{8'h85, 3'd3, 32'h11223300, 3'd3, 32'h00000000};  // write 5..7
    vecs[1] = '{8'h05, 3'd3, 32'h00000000, 3'd0, 32'h11223300};  // read 5..7
    vecs[2] = '{8'hC6, 3'd3, 32'hAABBCC00, 3'd2, 32'h00000000};  // 70,71 kept; 72 dropped
    vecs[3] = '{8'h46, 3'd3, 32'h00000000, 3'd0, 32'hAABB0000};  // 72 reads as 0
    vecs[4] = '{8'hFF, 3'd2, 32'h12340000, 3'd1, 32'h00000000};  // 127 dropped, wraps to 0
    vecs[5] = '{8'h7F, 3'd2, 32'h00000000, 3'd0, 32'h00340000};  // read wrap 127 -> 0
    vecs[6] = '{8'h00, 3'd0, 32'h00000000, 3'd0, 32'h00000000};  // command byte alone
    vecs[7] = '{8'h87, 3'd1, 32'h5A000000, 3'd1, 32'h00000000};  // overwrite 7
    vecs[8] = '{8'h06, 3'd2, 32'h00000000, 3'd0, 32'h225A0000};  // read 6,7

    reset = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    model_reset();
    tick(3);
    reset = 1'b0;
    tick(4);

    // Reset state
    check_bus("reset bus");
    check("reset MISO", MISO, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset strobe", cfg_wr_strobe, 1'b0);
    check("reset wr_addr", cfg_wr_addr, '0);
    check("reset strobe count", got_addr.size(), 0);

    // Table-driven directed frames
    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].cmd, int'(vecs[i].n), vecs[i].d, dut_rd, mdl_rd);
      check($sformatf("vec%0d strobe count", i), got_addr.size(), int'(vecs[i].strobes));
      if (!vecs[i].cmd[7]) check($sformatf("vec%0d readback", i), dut_rd, vecs[i].rd);
      check_strobes($sformatf("vec%0d", i));
      check_bus($sformatf("vec%0d", i));
      check($sformatf("vec%0d MISO idle", i), MISO, 1'b0);
    end

    // Read aborted mid-byte: MISO carries live data, then drops once SS rises
    clear_queues();
    exp_byte = mdl_mem[6];
    SS = 1'b0;
    tick(HALF);
    check("busy in frame", busy, 1'b1);
    spi_bits(8'h06, 8, b);
    spi_bits(8'h00, 2, b);
    tick(HALF);
    check("read abort live bit", MISO, exp_byte[5]);
    SS = 1'b1;
    tick(HALF);
    check("read abort MISO", MISO, 1'b0);
    check("read abort busy", busy, 1'b0);

    // Write aborted after 5 data bits: nothing committed, back to IDLE
    clear_queues();
    SS = 1'b0;
    tick(HALF);
    spi_bits(8'h80, 8, b);
    spi_bits(8'hFF, 5, b);
    SS = 1'b1;
    tick(2 * HALF);
    check("abort strobe count", got_addr.size(), 0);
    check_bus("abort bus");
    check("abort busy", busy, 1'b0);
    run_frame(8'h82, 1, 32'h77000000, dut_rd, mdl_rd);
    check_strobes("after abort");
    check_bus("after abort");

    // Randomized frames against the model, biased toward the address boundaries
    for (int t = 0; t < 24; t++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      cmd[6:0] = 7'($urandom_range(64, 79));
      else if (sel == 1) cmd[6:0] = 7'($urandom_range(124, 127));
      else               cmd[6:0] = 7'($urandom_range(0, 127));
      cmd[7] = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 4);
      d = $urandom;
      run_frame(cmd, n, d, dut_rd, mdl_rd);
      if (!cmd[7]) check($sformatf("rand%0d cmd %h readback", t, cmd), dut_rd, mdl_rd);
      check_strobes($sformatf("rand%0d cmd %h", t, cmd));
      check_bus($sformatf("rand%0d", t));
    end

    // Reset pulsed during a write data byte
    clear_queues();
    SS = 1'b0;
    tick(HALF);
    spi_bits(8'h83, 8, b);
    spi_bits(8'h5A, 4, b);
    reset = 1'b1;
    model_reset();
    tick(1);
    check_bus("mid-frame reset bus");
    check("mid-frame reset busy", busy, 1'b0);
    check("mid-frame reset MISO", MISO, 1'b0);
    tick(1);
    reset = 1'b0;
    SS = 1'b1;
    tick(2 * HALF);
    check("mid-frame reset strobes", got_addr.size(), 0);
    run_frame(8'h81, 1, 32'h5A000000, dut_rd, mdl_rd);
    check_strobes("post reset");
    check("post reset mem1", config_bus[15:8], 8'h5A);
    check_bus("post reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
